// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display blocks.
// Segment codes are active low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Per-frame copy of everything the display shows.
  typedef struct packed {
    logic [3:0] nib1;
    logic [3:0] nib2;
    logic [3:0] sum;
    logic       carry;
    logic [1:0] separator;
  } snap_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Hex nibble to active-low 7-segment code, {g,f,e,d,c,b,a}.
// Ports: i_hex  - 4-bit value to display
//        o_seg_c - combinational segment pattern
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg_c
);

  always_comb begin
    o_seg_c = SEG_BLANK;
    case (i_hex)
      4'h0: o_seg_c = SEG_0;
      4'h1: o_seg_c = SEG_1;
      4'h2: o_seg_c = SEG_2;
      4'h3: o_seg_c = SEG_3;
      4'h4: o_seg_c = SEG_4;
      4'h5: o_seg_c = SEG_5;
      4'h6: o_seg_c = SEG_6;
      4'h7: o_seg_c = SEG_7;
      4'h8: o_seg_c = SEG_8;
      4'h9: o_seg_c = SEG_9;
      4'hA: o_seg_c = SEG_A;
      4'hB: o_seg_c = SEG_B;
      4'hC: o_seg_c = SEG_C;
      4'hD: o_seg_c = SEG_D;
      4'hE: o_seg_c = SEG_E;
      4'hF: o_seg_c = SEG_F;
      default: o_seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed driver for a 4-digit common-anode 7-segment display.
// Each digit slot is BLANK_CYCLES of all-off followed by the digit, to
// avoid ghosting. Inputs are snapshotted once per frame (start of idx 0).
// Ports: clk, rst_n (async active low)
//        nib1 -> digit 3, nib2 -> digit 2, carry -> digit 1, sum -> digit 0
//        separator[1]/[0] -> DP on digit 3/2
//        an (active-low anodes), seg {g..a} and dp (active-low cathodes)
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV   = 100000,
  parameter int unsigned BLANK_CYCLES  = 1000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] nib1,
  input  logic [3:0] nib2,
  input  logic [3:0] sum,
  input  logic       carry,
  input  logic [1:0] separator,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  // Reject parameter sets that leave no SHOW cycles or no blank gap.
  if (BLANK_CYCLES == 0 || REFRESH_DIV <= BLANK_CYCLES + 1) begin : g_bad_params
    $error("seg7_scan_driver: need BLANK_CYCLES >= 1 and REFRESH_DIV > BLANK_CYCLES + 1");
  end

  scan_state_t      r_state;
  scan_state_t      w_state_d;
  logic [1:0]       r_idx;
  logic [1:0]       w_idx_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  snap_t            r_snap;
  snap_t            w_snap_d;
  snap_t            w_live;
  logic             w_cap;

  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic [3:0]       w_an_d;
  logic [6:0]       w_seg_d;
  logic             w_dp_d;

  logic [3:0]       w_nib;
  logic [6:0]       w_hex_seg;

  assign w_live = '{nib1: nib1, nib2: nib2, sum: sum, carry: carry, separator: separator};

  // Frame start: first BLANK cycle of digit 0.
  assign w_cap = (r_state == BLANK) && (r_idx == 2'd0) && (r_cnt == '0);

  // Next state, slot counter, digit index and snapshot.
  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_cnt_d   = r_cnt + CNT_W'(1);
    w_snap_d  = w_cap ? w_live : r_snap;

    if (r_cnt == CNT_LAST) begin
      w_cnt_d = '0;
    end

    case (r_state)
      BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_d = SHOW;
        end
      end
      SHOW: begin
        if (r_cnt == CNT_LAST) begin
          w_state_d = BLANK;
          w_idx_d   = r_idx + 2'd1;
        end
      end
      default: w_state_d = BLANK;
    endcase
  end

  // Nibble to decode for the digit that will be driven next cycle.
  always_comb begin
    w_nib = w_snap_d.sum;
    case (w_idx_d)
      2'd0: w_nib = w_snap_d.sum;
      2'd1: w_nib = {3'b000, w_snap_d.carry};
      2'd2: w_nib = w_snap_d.nib2;
      2'd3: w_nib = w_snap_d.nib1;
      default: w_nib = w_snap_d.sum;
    endcase
  end

  hex_to_seg7 u_hex (
    .i_hex   (w_nib),
    .o_seg_c (w_hex_seg)
  );

  // Output values are derived from the next state so that the registered
  // outputs switch on the same edge as the state and index.
  always_comb begin
    w_an_d  = 4'b1111;
    w_seg_d = SEG_BLANK;
    w_dp_d  = 1'b1;

    if (w_state_d == SHOW) begin
      w_an_d  = ~(4'b0001 << w_idx_d);
      w_seg_d = w_hex_seg;
      case (w_idx_d)
        2'd1: begin
          if (!w_snap_d.carry && BLANK_LEADING) begin
            w_seg_d = SEG_BLANK;
          end
        end
        2'd2: w_dp_d = ~w_snap_d.separator[0];
        2'd3: w_dp_d = ~w_snap_d.separator[1];
        default: w_dp_d = 1'b1;
      endcase
    end
  end

  // State, counters, snapshot and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BLANK;
      r_idx   <= 2'd0;
      r_cnt   <= '0;
      r_snap  <= '0;
      r_an    <= 4'b1111;
      r_seg   <= SEG_BLANK;
      r_dp    <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_cnt   <= w_cnt_d;
      r_snap  <= w_snap_d;
      r_an    <= w_an_d;
      r_seg   <= w_seg_d;
      r_dp    <= w_dp_d;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=8, BLANK_CYCLES=2.
// Two instances share inputs: BLANK_LEADING=1 (u_dut1) and 0 (u_dut0).
module tb_seg7_scan_driver;

  logic       clk;
  logic       rst_n;
  logic [3:0] nib1;
  logic [3:0] nib2;
  logic [3:0] sum;
  logic       carry;
  logic [1:0] separator;
  logic [3:0] an1, an0;
  logic [6:0] seg1, seg0;
  logic       dp1, dp0;

  int checks = 0;
  int errors = 0;

  localparam logic [11:0] ALL_OFF = {4'b1111, 7'b1111111, 1'b1};

  seg7_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .BLANK_LEADING(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .nib1(nib1), .nib2(nib2), .sum(sum), .carry(carry),
    .separator(separator), .an(an1), .seg(seg1), .dp(dp1)
  );

  seg7_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .BLANK_LEADING(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .nib1(nib1), .nib2(nib2), .sum(sum), .carry(carry),
    .separator(separator), .an(an0), .seg(seg0), .dp(dp0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed={an,seg,dp}=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  // One 8-cycle slot starting from the cycle where cnt=0 of that slot:
  // after edge 1 still blank, edges 2..7 show the digit, edge 8 is the
  // first blank cycle of the following slot.
  task automatic run_slot(input string name, input logic [1:0] idx,
                          input logic [6:0] exp_seg1, input logic [6:0] exp_seg0,
                          input logic exp_dp);
    logic [3:0] exp_an;
    exp_an = ~(4'b0001 << idx);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k >= 2 && k <= 7) begin
        chk($sformatf("%s_k%0d_lead1", name, k), {an1, seg1, dp1}, {exp_an, exp_seg1, exp_dp});
        chk($sformatf("%s_k%0d_lead0", name, k), {an0, seg0, dp0}, {exp_an, exp_seg0, exp_dp});
      end else begin
        chk($sformatf("%s_k%0d_blank1", name, k), {an1, seg1, dp1}, ALL_OFF);
        chk($sformatf("%s_k%0d_blank0", name, k), {an0, seg0, dp0}, ALL_OFF);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    nib1      = 4'hA;
    nib2      = 4'h5;
    sum       = 4'hF;
    carry     = 1'b1;
    separator = 2'b11;

    // Reset held for 5 cycles: all dark.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("reset_c%0d", i), {an1, seg1, dp1}, ALL_OFF);
    end
    rst_n = 1'b1;

    // Frame 1: A 5 carry=1 F, separator 11.
    run_slot("f1s0", 2'd0, 7'b0001110, 7'b0001110, 1'b1);
    run_slot("f1s1", 2'd1, 7'b1111001, 7'b1111001, 1'b1);
    run_slot("f1s2", 2'd2, 7'b0010010, 7'b0010010, 1'b0);
    run_slot("f1s3", 2'd3, 7'b0001000, 7'b0001000, 1'b0);

    // Between frames: sum=3, carry=0, separator 00.
    sum       = 4'h3;
    carry     = 1'b0;
    separator = 2'b00;
    run_slot("f2s0", 2'd0, 7'b0110000, 7'b0110000, 1'b1);
    run_slot("f2s1", 2'd1, 7'b1111111, 7'b1000000, 1'b1);
    // Mid-frame change of sum must not appear until the next frame.
    sum = 4'h7;
    run_slot("f2s2", 2'd2, 7'b0010010, 7'b0010010, 1'b1);
    run_slot("f2s3", 2'd3, 7'b0001000, 7'b0001000, 1'b1);

    run_slot("f3s0", 2'd0, 7'b1111000, 7'b1111000, 1'b1);
    run_slot("f3s1", 2'd1, 7'b1111111, 7'b1000000, 1'b1);

    // Into SHOW of digit 2, then async reset between clock edges.
    for (int k = 1; k <= 4; k++) tick();
    chk("f3s2_show_before_rst", {an1, seg1, dp1}, {4'b1011, 7'b0010010, 1'b1});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_immediate1", {an1, seg1, dp1}, ALL_OFF);
    chk("async_rst_immediate0", {an0, seg0, dp0}, ALL_OFF);
    tick();
    chk("async_rst_held", {an1, seg1, dp1}, ALL_OFF);
    rst_n = 1'b1;

    // Scan restarts at digit 0 with a blank gap first.
    run_slot("r_s0", 2'd0, 7'b1111000, 7'b1111000, 1'b1);
    run_slot("r_s1", 2'd1, 7'b1111111, 7'b1000000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
